// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: machine word, MEM-stage sequencer states, address masks.
// Latency: none (type/constant definitions only).
// Backpressure: not applicable.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // MEM-stage access sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PTR_READ = 2'd1,
        ACCESS   = 2'd2,
        DONE     = 2'd3
    } mem_access_state_t;

    // Clears bit 0 so word accesses are always aligned
    localparam lc3b_word WORD_MASK = 16'hFFFE;

endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: one data-memory access (LDR/STR/LDB/STB) or two (LDI/STI pointer + final).
// Latency: request to done = 3 cycles direct, 4 indirect with a 1-cycle memory; plus extra wait cycles.
// Backpressure: stall holds upstream stages from the accept cycle until the access completes; done pulses once.
module mem_access_unit
    import lc3b_types::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        indirect_in,
    input  logic [1:0]  byte_enable_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] wdata_in,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic        stall,
    output logic [15:0] rdata_out,
    output logic        done,
    output logic        timeout_err
);

    // Last count value before the watchdog fires; only meaningful when enabled
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    mem_access_state_t state;

    // Request registers: authoritative copy of the instruction for the whole access
    lc3b_word    req_addr;
    lc3b_word    req_wdata;
    logic [1:0]  req_be;
    logic        req_rd;
    logic        req_ind;
    lc3b_word    pointer;
    logic [15:0] wd_cnt;

    logic        accept;
    logic        wd_expire;
    lc3b_word    access_addr;

    // New memory instruction seen while idle; read wins if both read and write are set
    assign accept    = (state == IDLE) && valid_in && (mem_read_in || mem_write_in);
    assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);
    assign done      = (state == DONE);

    // Final-access address: pointer for indirect, aligned for word accesses
    always_comb begin
        access_addr = req_ind ? pointer : req_addr;
        if (req_be == 2'b11) begin
            access_addr = access_addr & WORD_MASK;
        end
    end

    // Memory port and stall decode from the current state and latched request
    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = 16'h0000;
        dmem_wdata       = 16'h0000;
        dmem_byte_enable = 2'b00;
        stall            = 1'b0;
        case (state)
            IDLE: begin
                stall = accept && !reset;
            end
            PTR_READ: begin
                dmem_read        = 1'b1;
                dmem_byte_enable = 2'b11;
                dmem_address     = req_addr & WORD_MASK;
                stall            = !reset;
            end
            ACCESS: begin
                dmem_read        = req_rd;
                dmem_write       = !req_rd;
                dmem_address     = access_addr;
                dmem_byte_enable = req_be;
                dmem_wdata       = req_wdata;
                stall            = !reset;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with request capture, watchdog and load-data return
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_addr    <= 16'h0000;
            req_wdata   <= 16'h0000;
            req_be      <= 2'b00;
            req_rd      <= 1'b0;
            req_ind     <= 1'b0;
            pointer     <= 16'h0000;
            wd_cnt      <= 16'h0000;
            rdata_out   <= 16'h0000;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wd_cnt <= 16'h0000;
                    if (accept) begin
                        req_addr  <= addr_in;
                        req_wdata <= wdata_in;
                        req_be    <= byte_enable_in;
                        req_rd    <= mem_read_in;
                        req_ind   <= indirect_in;
                        state     <= indirect_in ? PTR_READ : ACCESS;
                    end
                end
                PTR_READ: begin
                    if (dmem_resp) begin
                        pointer <= dmem_rdata;
                        wd_cnt  <= 16'h0000;
                        state   <= ACCESS;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        if (req_rd) begin
                            rdata_out <= 16'h0000;
                        end
                        wd_cnt <= 16'h0000;
                        state  <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        if (req_rd) begin
                            rdata_out <= dmem_rdata;
                        end
                        wd_cnt <= 16'h0000;
                        state  <= DONE;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        if (req_rd) begin
                            rdata_out <= 16'h0000;
                        end
                        wd_cnt <= 16'h0000;
                        state  <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
                end
                DONE: begin
                    wd_cnt <= 16'h0000;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small latency-programmable data-memory model.
// Latency: not applicable.
// Backpressure: memory response timing is set per vector.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        indirect_in;
    logic [1:0]  byte_enable_in;
    logic [15:0] addr_in;
    logic [15:0] wdata_in;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [15:0] dmem_address;
    logic [15:0] dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic        stall;
    logic [15:0] rdata_out;
    logic        done;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    // Memory model controls
    int          lat = 1;
    logic        mem_en = 1'b1;
    logic [15:0] mem_default = 16'h0000;
    int          wcnt = 0;

    // Per-operation observations
    int          n_stall, n_rd, n_wr, done_at, done_cnt, n_rd_done;
    logic        stall0;
    logic [15:0] rdata_at_done, rd_a0, rd_a1, wr_a, wr_d;
    logic [1:0]  wr_be;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_in         (valid_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .indirect_in      (indirect_in),
        .byte_enable_in   (byte_enable_in),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .stall            (stall),
        .rdata_out        (rdata_out),
        .done             (done),
        .timeout_err      (timeout_err)
    );

    // Response arrives in the lat-th cycle of a continuous strobe
    assign dmem_resp  = mem_en && (dmem_read || dmem_write) && (wcnt == lat - 1);
    assign dmem_rdata = (dmem_address == 16'h3000) ? 16'h4002 :
                        (dmem_address == 16'h4002) ? 16'h1234 : mem_default;

    always @(posedge clk) begin
        if ((dmem_read || dmem_write) && !dmem_resp) wcnt <= wcnt + 1;
        else                                         wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one memory instruction, then observe ncyc cycles; inputs are scrambled after accept
    task automatic run_op(input logic rd, input logic wr, input logic ind, input logic [1:0] be,
                          input logic [15:0] a, input logic [15:0] wd, input int ncyc);
        n_stall = 0; n_rd = 0; n_wr = 0; done_at = -1; done_cnt = 0; n_rd_done = 0;
        stall0 = 1'b0; rdata_at_done = 16'hDEAD; rd_a0 = 16'hDEAD; rd_a1 = 16'hDEAD;
        wr_a = 16'hDEAD; wr_d = 16'hDEAD; wr_be = 2'b00;
        valid_in = 1'b1; mem_read_in = rd; mem_write_in = wr; indirect_in = ind;
        byte_enable_in = be; addr_in = a; wdata_in = wd;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (i == 0) stall0 = stall;
            if (stall) n_stall++;
            if (dmem_read) begin
                n_rd++;
                if (dmem_resp) begin
                    if (n_rd_done == 0) rd_a0 = dmem_address;
                    else                rd_a1 = dmem_address;
                    n_rd_done++;
                end
            end
            if (dmem_write) begin
                n_wr++;
                if (dmem_resp) begin
                    wr_a = dmem_address; wr_d = dmem_wdata; wr_be = dmem_byte_enable;
                end
            end
            if (done) begin
                done_cnt++;
                done_at = i;
                rdata_at_done = rdata_out;
            end
            tick();
            if (i == 0) begin
                valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
                indirect_in = ~ind; byte_enable_in = ~be; addr_in = 16'hFFFF; wdata_in = 16'h5555;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1; valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        indirect_in = 1'b0; byte_enable_in = 2'b00; addr_in = 16'h0; wdata_in = 16'h0;
        tick(); tick();
        // Reset values, including a pending request that must not stall
        valid_in = 1'b1; mem_read_in = 1'b1;
        @(negedge clk);
        chk("rst_read",  dmem_read, 0);
        chk("rst_write", dmem_write, 0);
        chk("rst_addr",  dmem_address, 16'h0000);
        chk("rst_be",    dmem_byte_enable, 2'b00);
        chk("rst_stall", stall, 0);
        chk("rst_done",  done, 0);
        chk("rst_rdata", rdata_out, 16'h0000);
        chk("rst_tmo",   timeout_err, 0);
        valid_in = 1'b0; mem_read_in = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // LDR 0x1003, 2-cycle memory
        lat = 2; mem_default = 16'hBEEF;
        run_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h1003, 16'h0000, 5);
        chk("ldr_addr",  rd_a0, 16'h1002);
        chk("ldr_rdcyc", n_rd, 2);
        chk("ldr_stall", n_stall, 3);
        chk("ldr_doneat", done_at, 3);
        chk("ldr_ndone", done_cnt, 1);
        chk("ldr_rdata", rdata_at_done, 16'hBEEF);

        // STB 0x2001, upper byte
        lat = 1;
        run_op(1'b0, 1'b1, 1'b0, 2'b10, 16'h2001, 16'hAB00, 4);
        chk("stb_addr",  wr_a, 16'h2001);
        chk("stb_be",    wr_be, 2'b10);
        chk("stb_wdata", wr_d, 16'hAB00);
        chk("stb_rdcyc", n_rd, 0);
        chk("stb_doneat", done_at, 2);
        chk("stb_stall", n_stall, 2);

        // LDI 0x3000 -> pointer 0x4002 -> 0x1234
        run_op(1'b1, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h0000, 5);
        chk("ldi_ptr",   rd_a0, 16'h3000);
        chk("ldi_fin",   rd_a1, 16'h4002);
        chk("ldi_rdata", rdata_at_done, 16'h1234);
        chk("ldi_doneat", done_at, 3);
        chk("ldi_ndone", done_cnt, 1);

        // ADD (no memory) immediately followed by STR 0x5005 word
        valid_in = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0;
        @(negedge clk);
        chk("add_stall", stall, 0);
        chk("add_read",  dmem_read, 0);
        tick();
        run_op(1'b0, 1'b1, 1'b0, 2'b11, 16'h5005, 16'h1357, 4);
        chk("str_stall0", stall0, 1);
        chk("str_addr",  wr_a, 16'h5004);
        chk("str_wdata", wr_d, 16'h1357);
        chk("str_doneat", done_at, 2);

        // LDB with read and write both set: read wins, odd address kept
        mem_default = 16'h00C3;
        run_op(1'b1, 1'b1, 1'b0, 2'b01, 16'h2001, 16'h9999, 4);
        chk("ldb_wrcyc", n_wr, 0);
        chk("ldb_addr",  rd_a0, 16'h2001);
        chk("ldb_rdata", rdata_at_done, 16'h00C3);

        // Reset while waiting on the pointer read
        mem_en = 1'b0;
        valid_in = 1'b1; mem_read_in = 1'b1; indirect_in = 1'b1; byte_enable_in = 2'b11;
        addr_in = 16'h3000;
        tick();
        valid_in = 1'b0; mem_read_in = 1'b0; indirect_in = 1'b0;
        @(negedge clk);
        chk("ptr_read",  dmem_read, 1);
        chk("ptr_addr",  dmem_address, 16'h3000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_read",  dmem_read, 0);
        chk("abort_stall", stall, 0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("abort_ndone", done_cnt, 0);
        chk("abort_rdata", rdata_out, 16'h0000);

        // Restore a nonzero load result so the timeout clear is visible
        mem_en = 1'b1; mem_default = 16'h7777;
        tick();
        run_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h0100, 16'h0000, 4);
        chk("pre_rdata", rdata_at_done, 16'h7777);

        // Watchdog: no response, 8 cycles in ACCESS
        mem_en = 1'b0;
        run_op(1'b1, 1'b0, 1'b0, 2'b11, 16'h6000, 16'h0000, 12);
        chk("tmo_rdcyc", n_rd, 8);
        chk("tmo_doneat", done_at, 9);
        chk("tmo_ndone", done_cnt, 1);
        chk("tmo_rdata", rdata_at_done, 16'h0000);
        chk("tmo_flag",  timeout_err, 1);

        // Flag is sticky across a normal access, cleared only by reset
        mem_en = 1'b1;
        run_op(1'b0, 1'b1, 1'b0, 2'b11, 16'h0200, 16'h0042, 4);
        chk("tmo_sticky", timeout_err, 1);
        chk("post_doneat", done_at, 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("tmo_clear", timeout_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
